ahb_refill_arbiter: RTL and testbench
=====================================

// Module: ahb_refill_arbiter
// PURPOSE
//  Shares one AHB-lite master port to memory between two line-refill requesters
//  (port 0: I-cache, port 1: second cache/prefetcher). Each grant runs one read
//  WRAP4 burst, critical word first, returning 4 x 32-bit beats tagged with the
//  requester id. Sits between the cache miss logic and the downstream ahb_lite master.
// PARAMETERS
//  ADDR_W  32  address width (byte address)
//  DATA_W  32  beat width; fixed 32 (hsize=WORD)
// PORTS
//  hclk        in   1       clock, all logic on rising edge
//  hrst        in   1       reset, synchronous, active-high
//  req_valid   in   2       per-requester refill request; held until req_ready
//  req_addr0   in   ADDR_W  port 0 miss address (word aligned)
//  req_addr1   in   ADDR_W  port 1 miss address (word aligned)
//  req_ready   out  2       one-hot, 1-cycle accept pulse
//  resp_valid  out  1       beat returned this cycle
//  resp_id     out  1       owner of current burst
//  resp_off    out  2       word offset (haddr[3:2]) of returned beat
//  resp_data   out  DATA_W  beat data
//  resp_last   out  1       with resp_valid: final beat, burst complete
//  resp_err    out  1       1-cycle pulse: burst aborted by ERROR response
//  m_haddr     out  ADDR_W  AHB address
//  m_htrans    out  2       IDLE=0 NONSEQ=2 SEQ=3 (BUSY never issued)
//  m_hburst    out  3       constant WRAP4 (3'b010)
//  m_hsize     out  3       constant 3'b010;  m_hwrite out 1 constant 0
//  m_hready    in   1       AHB ready;  m_hresp in 1 (1=ERROR);  m_hrdata in DATA_W
// BEHAVIOUR
//  Reset (hrst=1 at edge): FSM=IDLE, beat cnt=0, last_grant=1 (port 0 wins first
//   tie), req_ready=0, resp_*=0, m_htrans=IDLE, m_haddr=0. Reset mid-burst aborts
//   immediately, no resp_last/resp_err; requesters reissue.
//  FSM: IDLE -> ADDR -> BURST -> LAST -> IDLE; any -> ERR -> IDLE.
//   IDLE: any req_valid -> grant, latch addr+id, req_ready[id]=1 during ADDR.
//   ADDR: m_htrans=NONSEQ, m_haddr=latched addr. hready=1 -> BURST, cnt=1.
//   BURST: m_htrans=SEQ, m_haddr={addr[31:4], addr[3:2]+cnt, 2'b00} (mod-4 wrap
//    inside 16-byte line). hready=1 advances cnt; after cnt=3 accepted -> LAST.
//   LAST: m_htrans=IDLE, data phase of beat 3. hready=1 -> IDLE.
//  Pipelining: data of beat n captured in cycle after its address phase, when
//   m_hready=1 and m_hresp=0: resp_valid=1 combinationally with m_hrdata,
//   resp_off=offset of that beat. resp_last with 4th beat. 
//  Wait states: m_hready=0 holds m_haddr/m_htrans/cnt; no resp_valid.
//  Latency (zero wait): req seen cycle T -> NONSEQ T+1, SEQ T+2..T+4, beats
//   T+2..T+5, resp_last T+5, next NONSEQ earliest T+7.
//  Error: m_hresp=1 & m_hready=0 (1st error cycle) -> drive m_htrans=IDLE that
//   cycle and next, enter ERR; resp_err=1 on 2nd cycle (hready=1); -> IDLE. No
//   resp_last for aborted burst. Beats delivered before error stay valid.
//  Arbitration (round robin): both valid in IDLE -> grant !last_grant;
//   last_grant updated at grant. Single valid -> granted. New request during a
//   burst waits; req_valid deassert before ready is illegal (assertion).
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: port 0 always wins ties; last_grant unused/removed.
//  Undefined: round robin as above.
// TESTING
//  1 p0 addr 0x1008, zero wait -> haddr 1008,100C,1000,1004; htrans N,S,S,S;
//    resp_off 2,3,0,1; resp_last at 4th beat; ready pulse 1 cycle.
//  2 p0,p1 valid same cycle twice (0x2000,0x3000) -> RR: p0 burst then p1;
//    fixed-prio build: p0 both times while held; p1 only when p0 idle.
//  3 hready low 2 cycles at beat 2 -> haddr/htrans held, 2-cycle gap in
//    resp_valid, data order unchanged, resp_last 2 cycles later.
//  4 ERROR on beat 1 -> beat 0 delivered, htrans IDLE 2 cycles, resp_err 1
//    pulse, no resp_last; pending p1 granted next.
//  5 hrst during BURST cnt=2 -> next cycle htrans=IDLE, all resp_*=0, FSM IDLE;
//    reissued request completes normally.
//  6 Back-to-back p1 requests -> one IDLE cycle between bursts, ids correct.

Source files
------------

// File: rtl/ahb_refill_arbiter.sv
// Two-port line-refill arbiter driving one AHB-lite read master with WRAP4 bursts.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round robin.
module ahb_refill_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        req_ready,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [1:0]        resp_off,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_err,
    output logic [ADDR_W-1:0] m_haddr,
    output logic [1:0]        m_htrans,
    output logic [2:0]        m_hburst,
    output logic [2:0]        m_hsize,
    output logic              m_hwrite,
    input  logic              m_hready,
    input  logic              m_hresp,
    input  logic [DATA_W-1:0] m_hrdata
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    typedef enum logic [2:0] {StIdle, StAddr, StBurst, StLast, StErr} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              id_q, id_d;
    logic [1:0]        ready_q, ready_d;
    logic              grant_id;
    logic [1:0]        base_off;
    logic [1:0]        seq_off;
    logic              data_phase;
    logic              err_first;
`ifndef ARB_FIXED_PRIO_EN
    logic              last_grant_q, last_grant_d;
`endif

    assign m_hburst  = 3'b010;
    assign m_hsize   = 3'b010;
    assign m_hwrite  = 1'b0;
    assign req_ready = ready_q;
    assign resp_id   = id_q;

    assign base_off   = addr_q[3:2];
    assign seq_off    = base_off + cnt_q;
    assign data_phase = (state_q == StBurst) || (state_q == StLast);
    // First cycle of the two-cycle AHB ERROR response.
    assign err_first  = data_phase && m_hresp && !m_hready;

`ifdef ARB_FIXED_PRIO_EN
    assign grant_id = ~req_valid[0];
`else
    assign grant_id = (&req_valid) ? ~last_grant_q : req_valid[1];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        id_d     = id_q;
        ready_d  = 2'b00;
        m_htrans = TransIdle;
        m_haddr  = '0;
`ifndef ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    state_d = StAddr;
                    addr_d  = grant_id ? req_addr1 : req_addr0;
                    id_d    = grant_id;
                    ready_d = grant_id ? 2'b10 : 2'b01;
`ifndef ARB_FIXED_PRIO_EN
                    last_grant_d = grant_id;
`endif
                end
            end
            StAddr: begin
                m_htrans = TransNonseq;
                m_haddr  = addr_q;
                if (m_hready) begin
                    state_d = StBurst;
                    cnt_d   = 2'd1;
                end
            end
            StBurst: begin
                if (err_first) begin
                    state_d = StErr;
                    cnt_d   = 2'd0;
                end else begin
                    m_htrans = TransSeq;
                    m_haddr  = {addr_q[ADDR_W-1:4], seq_off, 2'b00};
                    if (m_hready) begin
                        if (cnt_q == 2'd3) begin
                            state_d = StLast;
                            cnt_d   = 2'd0;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
            end
            StLast: begin
                if (err_first) begin
                    state_d = StErr;
                end else if (m_hready) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                if (m_hready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data for the beat whose address phase completed last cycle.
    always_comb begin
        resp_valid = data_phase && m_hready && !m_hresp;
        resp_off   = (state_q == StLast) ? (base_off + 2'd3) : (base_off + cnt_q - 2'd1);
        resp_data  = resp_valid ? m_hrdata : '0;
        resp_last  = resp_valid && (state_q == StLast);
        resp_err   = (state_q == StErr) && m_hready;
        if (!resp_valid) begin
            resp_off = 2'd0;
        end
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            id_q    <= 1'b0;
            ready_q <= 2'b00;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            ready_q <= ready_d;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // A requester may only withdraw after its accept pulse.
    for (genvar i = 0; i < 2; i++) begin : g_req_hold
        assert property (@(posedge hclk) disable iff (hrst)
            (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
    end

endmodule

// File: tb/tb_ahb_refill_arbiter.sv
// Directed bench for ahb_refill_arbiter with a small AHB read slave returning
// address-derived data.
module tb_ahb_refill_arbiter;

    logic        hclk = 1'b0;
    logic        hrst;
    logic [1:0]  req_valid;
    logic [31:0] req_addr0, req_addr1;
    logic [1:0]  req_ready;
    logic        resp_valid, resp_id, resp_last, resp_err;
    logic [1:0]  resp_off;
    logic [31:0] resp_data;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hburst, m_hsize;
    logic        m_hwrite, m_hready, m_hresp;
    logic [31:0] m_hrdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 hclk = ~hclk;

    ahb_refill_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk      (hclk),
        .hrst      (hrst),
        .req_valid (req_valid),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_off  (resp_off),
        .resp_data (resp_data),
        .resp_last (resp_last),
        .resp_err  (resp_err),
        .m_haddr   (m_haddr),
        .m_htrans  (m_htrans),
        .m_hburst  (m_hburst),
        .m_hsize   (m_hsize),
        .m_hwrite  (m_hwrite),
        .m_hready  (m_hready),
        .m_hresp   (m_hresp),
        .m_hrdata  (m_hrdata)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // Slave: data phase follows an accepted address phase.
    logic [31:0] dp_addr;
    logic        dp_valid;
    always @(posedge hclk) begin
        if (hrst) begin
            dp_valid <= 1'b0;
            dp_addr  <= 32'h0;
        end else if (m_hready) begin
            dp_valid <= m_htrans[1];
            dp_addr  <= m_haddr;
        end
    end
    assign m_hrdata = dp_valid ? data_of(dp_addr) : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] trans, input logic [31:0] addr);
        check({tag, ".htrans"}, 32'(m_htrans), 32'(trans));
        if (trans != 2'b00) check({tag, ".haddr"}, m_haddr, addr);
    endtask

    task automatic chk_beat(input string tag, input logic vld, input int id,
                            input logic [31:0] base, input int off, input logic last);
        logic [1:0]  off2;
        logic [31:0] ba;
        off2 = 2'(off);
        ba   = {base[31:4], off2, 2'b00};
        check({tag, ".rvalid"}, 32'(resp_valid), 32'(vld));
        check({tag, ".rlast"}, 32'(resp_last), 32'(last));
        if (vld) begin
            check({tag, ".roff"}, 32'(resp_off), 32'(off2));
            check({tag, ".rid"}, 32'(resp_id), 32'(id));
            check({tag, ".rdata"}, resp_data, data_of(ba));
        end
    endtask

    // Entered in the NONSEQ cycle; returns in the final data-phase cycle.
    task automatic do_burst(input int id, input logic [31:0] a, input bit keep, input string tag);
        int o0;
        o0 = int'(a[3:2]);
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(1 << id));
        chk_bus({tag, ".n"}, 2'b10, a);
        chk_beat({tag, ".n"}, 1'b0, id, a, 0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            if (k == 1 && !keep) req_valid[id] = 1'b0;
            #1;
            if (k == 1) check({tag, ".ready_pulse"}, 32'(req_ready), 32'h0);
            chk_bus($sformatf("%s.s%0d", tag, k), 2'b11, {a[31:4], 2'(o0 + k), 2'b00});
            chk_beat($sformatf("%s.b%0d", tag, k - 1), 1'b1, id, a, (o0 + k - 1) % 4, 1'b0);
        end
        cyc();
        #1;
        chk_bus({tag, ".l"}, 2'b00, 32'h0);
        chk_beat({tag, ".b3"}, 1'b1, id, a, (o0 + 3) % 4, 1'b1);
    endtask

    task automatic do_reset();
        hrst = 1'b1;
        cyc();
        hrst = 1'b0;
    endtask

    initial begin
        int first;
        int second;
        hrst = 1'b1; req_valid = 2'b00; req_addr0 = 32'h0; req_addr1 = 32'h0;
        m_hready = 1'b1; m_hresp = 1'b0;
        cyc(); cyc(); #1;
        check("rst.htrans", 32'(m_htrans), 32'h0);
        check("rst.haddr", m_haddr, 32'h0);
        check("rst.ready", 32'(req_ready), 32'h0);
        check("rst.rvalid", 32'(resp_valid), 32'h0);
        check("rst.rerr", 32'(resp_err), 32'h0);
        check("rst.rlast", 32'(resp_last), 32'h0);
        check("const.hburst", 32'(m_hburst), 32'h2);
        check("const.hsize", 32'(m_hsize), 32'h2);
        check("const.hwrite", 32'(m_hwrite), 32'h0);

        // 1: single p0 burst, critical word first
        cyc(); hrst = 1'b0; req_valid = 2'b01; req_addr0 = 32'h1008; #1;
        chk_bus("t1.idle", 2'b00, 32'h0);
        cyc(); do_burst(0, 32'h1008, 1'b0, "t1");
        cyc(); #1;
        chk_bus("t1.gap", 2'b00, 32'h0);
        chk_beat("t1.gap", 1'b0, 0, 32'h0, 0, 1'b0);

        // 2: tie, p0 keeps requesting after its first grant
        do_reset();
        req_valid = 2'b11; req_addr0 = 32'h2000; req_addr1 = 32'h3000; #1;
        chk_bus("t2.idle", 2'b00, 32'h0);
        cyc(); do_burst(0, 32'h2000, 1'b1, "t2a");
`ifdef ARB_FIXED_PRIO_EN
        first = 0;
`else
        first = 1;
`endif
        second = 1 - first;
        cyc(); #1;
        chk_bus("t2.gap1", 2'b00, 32'h0);
        cyc(); do_burst(first, (first == 1) ? 32'h3000 : 32'h2000, 1'b0, "t2b");
        cyc(); #1;
        chk_bus("t2.gap2", 2'b00, 32'h0);
        cyc(); do_burst(second, (second == 1) ? 32'h3000 : 32'h2000, 1'b0, "t2c");

        // 3: two wait states on beat 2's data phase
        cyc(); req_valid = 2'b10; req_addr1 = 32'h4004; #1;
        chk_bus("t3.idle", 2'b00, 32'h0);
        cyc(); #1;
        check("t3.ready", 32'(req_ready), 32'h2);
        chk_bus("t3.n", 2'b10, 32'h4004);
        cyc(); req_valid = 2'b00; #1;
        chk_bus("t3.s1", 2'b11, 32'h4008);
        chk_beat("t3.b0", 1'b1, 1, 32'h4000, 1, 1'b0);
        cyc(); #1;
        chk_bus("t3.s2", 2'b11, 32'h400C);
        chk_beat("t3.b1", 1'b1, 1, 32'h4000, 2, 1'b0);
        cyc(); m_hready = 1'b0; #1;
        chk_bus("t3.w1", 2'b11, 32'h4000);
        chk_beat("t3.w1", 1'b0, 1, 32'h4000, 0, 1'b0);
        cyc(); #1;
        chk_bus("t3.w2", 2'b11, 32'h4000);
        chk_beat("t3.w2", 1'b0, 1, 32'h4000, 0, 1'b0);
        cyc(); m_hready = 1'b1; #1;
        chk_bus("t3.s3", 2'b11, 32'h4000);
        chk_beat("t3.b2", 1'b1, 1, 32'h4000, 3, 1'b0);
        cyc(); #1;
        chk_bus("t3.l", 2'b00, 32'h0);
        chk_beat("t3.b3", 1'b1, 1, 32'h4000, 0, 1'b1);

        // 4: ERROR on beat 1 with p1 pending
        cyc(); req_valid = 2'b01; req_addr0 = 32'h5000; #1;
        chk_bus("t4.idle", 2'b00, 32'h0);
        cyc(); #1;
        check("t4.ready", 32'(req_ready), 32'h1);
        chk_bus("t4.n", 2'b10, 32'h5000);
        cyc(); req_valid = 2'b10; req_addr1 = 32'h6000; #1;
        chk_bus("t4.s1", 2'b11, 32'h5004);
        chk_beat("t4.b0", 1'b1, 0, 32'h5000, 0, 1'b0);
        cyc(); m_hready = 1'b0; m_hresp = 1'b1; #1;
        chk_bus("t4.e1", 2'b00, 32'h0);
        check("t4.e1.rvalid", 32'(resp_valid), 32'h0);
        check("t4.e1.rerr", 32'(resp_err), 32'h0);
        cyc(); m_hready = 1'b1; #1;
        chk_bus("t4.e2", 2'b00, 32'h0);
        check("t4.e2.rerr", 32'(resp_err), 32'h1);
        chk_beat("t4.e2", 1'b0, 0, 32'h0, 0, 1'b0);
        cyc(); m_hresp = 1'b0; #1;
        chk_bus("t4.idle2", 2'b00, 32'h0);
        check("t4.idle2.rerr", 32'(resp_err), 32'h0);
        cyc(); do_burst(1, 32'h6000, 1'b0, "t4p1");

        // 5: reset in BURST with cnt=2, then reissue
        cyc(); req_valid = 2'b01; req_addr0 = 32'h7008; #1;
        chk_bus("t5.idle", 2'b00, 32'h0);
        cyc(); #1;
        chk_bus("t5.n", 2'b10, 32'h7008);
        cyc(); req_valid = 2'b00; #1;
        chk_bus("t5.s1", 2'b11, 32'h700C);
        cyc(); hrst = 1'b1; #1;
        chk_bus("t5.s2", 2'b11, 32'h7000);
        chk_beat("t5.b1", 1'b1, 0, 32'h7000, 3, 1'b0);
        cyc(); hrst = 1'b0; req_valid = 2'b01; #1;
        chk_bus("t5.rst", 2'b00, 32'h0);
        check("t5.rst.haddr", m_haddr, 32'h0);
        check("t5.rst.rerr", 32'(resp_err), 32'h0);
        check("t5.rst.ready", 32'(req_ready), 32'h0);
        check("t5.rst.rid", 32'(resp_id), 32'h0);
        chk_beat("t5.rst", 1'b0, 0, 32'h0, 0, 1'b0);
        cyc(); do_burst(0, 32'h7008, 1'b0, "t5r");

        // 6: back-to-back p1 requests
        cyc(); req_valid = 2'b10; req_addr1 = 32'h8004; #1;
        chk_bus("t6.idle", 2'b00, 32'h0);
        cyc(); do_burst(1, 32'h8004, 1'b1, "t6a");
        req_addr1 = 32'h9000;
        cyc(); #1;
        chk_bus("t6.gap", 2'b00, 32'h0);
        check("t6.gap.ready", 32'(req_ready), 32'h0);
        check("t6.gap.rvalid", 32'(resp_valid), 32'h0);
        cyc(); do_burst(1, 32'h9000, 1'b0, "t6b");

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
